// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register indices, reset constants,
// read-FSM states and register-destination mux select codes.
package mips_pkg;

    // Architectural register indices
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_FP   = 5'd30;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Stack pointer value after reset
    localparam int unsigned SP_RESET_DEFAULT = 227;

    // Operand snapshot FSM
    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_t;

    // Register-destination mux select codes (source of write_reg)
    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,  // I-type: Inst.20-16
        REGDST_RD = 2'd1,  // R-type: Inst.15-11
        REGDST_RA = 2'd2   // jal: link register
    } regdst_sel_t;

    // Destination index as produced by the register-destination mux
    function automatic logic [4:0] regdst_mux(input regdst_sel_t sel,
                                              input logic [4:0]  rt,
                                              input logic [4:0]  rd);
        logic [4:0] idx;
        unique case (sel)
            REGDST_RT: idx = rt;
            REGDST_RD: idx = rd;
            REGDST_RA: idx = REG_RA;
            default:   idx = REG_ZERO;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One read port of the register bank: R0 reads zero, a same-cycle write to
// the addressed register is forwarded, otherwise the stored value is returned.
module reg_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [4:0]        index,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] regs [32],
    output logic [DATA_W-1:0] value
);

    // Zero / bypass / array selection
    always_comb begin
        value = regs[index];
        if (index == REG_ZERO) begin
            value = '0;
        end else if (reg_write && (write_reg == index)) begin
            value = write_data;
        end
    end

endmodule

// File: rtl/reg_bank_reader.sv
// 32 x DATA_W register bank with write-to-read bypass and a valid/ack
// handshake that snapshots rs/rt into the A/B operand registers.
module reg_bank_reader
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SP_RESET = SP_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_req,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic              busy_wr
);

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    rd_state_t         state_q;
    rd_state_t         state_d;
    logic              capture;
    logic              wr_en;

    // R0 is never written so it stays at its reset value of zero
    assign wr_en = reg_write && (write_reg != REG_ZERO);

    // Register storage; SP comes out of reset at SP_RESET
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == int'(REG_SP)) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W)
    ) u_port_a (
        .index      (rs),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regs       (regs),
        .value      (val_a)
    );

    reg_read_port #(
        .DATA_W (DATA_W)
    ) u_port_b (
        .index      (rt),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regs       (regs),
        .value      (val_b)
    );

    // Next state and capture strobe; in VALID a new request only counts
    // once the consumer has acked the current snapshot
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (rd_req) begin
                    capture = 1'b1;
                    state_d = RD_VALID;
                end
            end
            RD_VALID: begin
                if (rd_ack) begin
                    if (rd_req) begin
                        capture = 1'b1;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand snapshot registers; held while not capturing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_out <= '0;
            B_out <= '0;
        end else if (capture) begin
            A_out <= val_a;
            B_out <= val_b;
        end
    end

    // Registered write-activity flag for trace
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_wr <= 1'b0;
        end else begin
            busy_wr <= wr_en;
        end
    end

    assign rd_valid = (state_q == RD_VALID);

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: directed vector table, hand-written
// reset-mid-handshake sequence, then randomized traffic against a model.
module tb_reg_bank_reader;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic          rd_req;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] A_out;
    logic [DW-1:0] B_out;
    logic          busy_wr;

    int chk;
    int errs;

    // Reference model state
    logic [DW-1:0] m_regs [32];
    logic          m_valid;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic          m_busy;

    typedef struct {
        logic          we;
        logic [4:0]    wr;
        logic [DW-1:0] wd;
        logic          req;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          ack;
        logic          e_valid;
        logic [DW-1:0] e_a;
        logic [DW-1:0] e_b;
        logic          e_busy;
    } vec_t;

    vec_t vecs [10];

    reg_bank_reader #(
        .DATA_W   (32),
        .SP_RESET (227)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .rd_req     (rd_req),
        .rs         (rs),
        .rt         (rt),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .A_out      (A_out),
        .B_out      (B_out),
        .busy_wr    (busy_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_regs[29] = 227;
        m_valid = 1'b0;
        m_a = '0;
        m_b = '0;
        m_busy = 1'b0;
    endtask

    // What a read of register idx returns this cycle
    function automatic logic [DW-1:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (reg_write && write_reg == idx) return write_data;
        return m_regs[idx];
    endfunction

    // Advance one clock with current inputs, then compare outputs to the model
    task automatic cycle();
        logic          n_valid;
        logic [DW-1:0] n_a;
        logic [DW-1:0] n_b;
        n_valid = m_valid;
        n_a = m_a;
        n_b = m_b;
        // A pending snapshot blocks new requests until the consumer acks it
        if (!m_valid || rd_ack) begin
            if (rd_req) begin
                n_valid = 1'b1;
                n_a = model_read(rs);
                n_b = model_read(rt);
            end else begin
                n_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_a = n_a;
        m_b = n_b;
        m_busy = reg_write && (write_reg != 5'd0);
        if (m_busy) m_regs[write_reg] = write_data;
        check("model rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        check("model A_out", A_out, m_a);
        check("model B_out", B_out, m_b);
        check("model busy_wr", {31'd0, busy_wr}, {31'd0, m_busy});
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [DW-1:0] wd,
                         input logic req, input logic [4:0] a, input logic [4:0] b,
                         input logic ack);
        reg_write = we;
        write_reg = wr;
        write_data = wd;
        rd_req = req;
        rs = a;
        rt = b;
        rd_ack = ack;
    endtask

    initial begin
        chk = 0;
        errs = 0;
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b0);
        model_reset();

        //        we   wr     wd            req  rs     rt     ack  valid A             B             busy
        vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd29, 5'd0,  1'b0, 1'b1, 32'd227,      32'd0,        1'b0};
        vecs[1] = '{1'b1, 5'd8,  32'h0000_00FF, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'd227,      32'd0,        1'b1};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  5'd8,  1'b0, 1'b1, 32'h0000_00FF, 32'h0000_00FF, 1'b0};
        vecs[3] = '{1'b1, 5'd9,  32'h1234_5678, 1'b1, 5'd9,  5'd8,  1'b1, 1'b1, 32'h1234_5678, 32'h0000_00FF, 1'b1};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'h1234_5678, 32'h0000_00FF, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 32'd0,        32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, 5'd9,  32'hAAAA_5555, 1'b1, 5'd8,  5'd8,  1'b0, 1'b1, 32'd0,        32'h1234_5678, 1'b1};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd29, 1'b1, 1'b1, 32'hAAAA_5555, 32'd227,      1'b0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'hAAAA_5555, 32'd227,      1'b0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd4,  1'b1, 1'b0, 32'hAAAA_5555, 32'd227,      1'b0};

        // Power-on reset
        #1 reset = 1'b1;
        #1;
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset A_out", A_out, 32'd0);
        check("reset B_out", B_out, 32'd0);
        check("reset busy_wr", {31'd0, busy_wr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].req, vecs[i].rs, vecs[i].rt,
                  vecs[i].ack);
            cycle();
            check($sformatf("vec%0d rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d A_out", i), A_out, vecs[i].e_a);
            check($sformatf("vec%0d B_out", i), B_out, vecs[i].e_b);
            check($sformatf("vec%0d busy_wr", i), {31'd0, busy_wr}, {31'd0, vecs[i].e_busy});
        end

        // Overwrite SP with bypassed snapshot, hold it, then reset mid-handshake
        drive(1'b1, 5'd29, 32'h0000_0055, 1'b1, 5'd29, 5'd29, 1'b0);
        cycle();
        check("sp bypass A_out", A_out, 32'h0000_0055);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd1, 5'd2, 1'b0);
        cycle();
        check("hold rd_valid", {31'd0, rd_valid}, 32'd1);
        check("hold A_out", A_out, 32'h0000_0055);
        #2 reset = 1'b1;
        #1;
        check("async rst rd_valid", {31'd0, rd_valid}, 32'd0);
        check("async rst A_out", A_out, 32'd0);
        check("async rst B_out", B_out, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b1, 5'd29, 5'd0, 1'b0);
        cycle();
        check("sp after reset", A_out, 32'd227);
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);
        cycle();

        // Randomized traffic, reads biased toward the register being written
        for (int n = 0; n < 600; n++) begin
            logic [4:0] w;
            w = 5'($urandom_range(0, 31));
            drive(1'($urandom % 2), w, $urandom, 1'($urandom % 2),
                  ($urandom % 3 == 0) ? w : 5'($urandom_range(0, 31)),
                  ($urandom % 3 == 0) ? w : 5'($urandom_range(0, 31)),
                  1'($urandom % 2));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
